// File: rtl/core_pkg.sv
// core_pkg: shared widths and memory-stage state encoding for the 64-bit core.
package core_pkg;
    localparam int XLEN = 64;
    localparam int REG_ADDR_W = 5;
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} mau_state_t;
endpackage

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage controller issuing doubleword loads/stores over a valid/ack port.
module mem_access_unit
    import core_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [XLEN-1:0]       alu_out,
    input  logic [XLEN-1:0]       data,
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic                  mem_to_reg,
    input  logic                  reg_write_en,
    output logic                  stall,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [XLEN-1:0]       mem_addr,
    output logic [XLEN-1:0]       mem_wdata,
    input  logic                  mem_ack,
    input  logic [XLEN-1:0]       mem_rdata,
    output logic [XLEN-1:0]       wb_result,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic                  wb_reg_write_en,
    output logic                  wb_valid,
    output logic                  mem_err
);
    localparam logic [7:0] TIMEOUT = 8'(TIMEOUT_CYCLES);

    mau_state_t state, state_n;
    logic [7:0] cnt, cnt_n;
    logic req_n, we_n, m2r_n, rwe_n, wb_we_n, valid_n, err_n;
    logic [XLEN-1:0] addr_n, wdata_n, res_n;
    logic [REG_ADDR_W-1:0] rd_n, wb_rd_n, lat_rd;
    logic lat_m2r, lat_rwe, mem_op, legal;

    assign mem_op = mem_read | mem_write;
    assign legal = (alu_out[2:0] == 3'd0) && (mem_read ^ mem_write);
    // Reset gating keeps stall low while the core is held in reset.
    assign stall = reset && ((state == IDLE && mem_op) || state == BUSY);

    always_comb begin
        state_n = state;
        cnt_n = cnt;
        req_n = mem_req;
        we_n = mem_we;
        addr_n = mem_addr;
        wdata_n = mem_wdata;
        rd_n = lat_rd;
        m2r_n = lat_m2r;
        rwe_n = lat_rwe;
        res_n = wb_result;
        wb_rd_n = wb_rd;
        wb_we_n = 1'b0;
        valid_n = 1'b0;
        err_n = 1'b0;
        case (state)
            IDLE: begin
                if (!mem_op) begin
                    res_n = alu_out;
                    wb_rd_n = rd;
                    wb_we_n = reg_write_en;
                    valid_n = 1'b1;
                end else if (legal) begin
                    state_n = BUSY;
                    cnt_n = 8'd0;
                    req_n = 1'b1;
                    we_n = mem_write;
                    addr_n = alu_out;
                    wdata_n = data;
                    rd_n = rd;
                    m2r_n = mem_to_reg;
                    rwe_n = reg_write_en;
                end else begin
                    state_n = DONE;
                    res_n = alu_out;
                    wb_rd_n = rd;
                    err_n = 1'b1;
                    valid_n = 1'b1;
                end
            end
            BUSY: begin
                cnt_n = cnt + 8'd1;
                // Ack wins over a timeout landing in the same cycle.
                if (mem_ack) begin
                    state_n = DONE;
                    req_n = 1'b0;
                    res_n = (!mem_we && lat_m2r) ? mem_rdata : mem_addr;
                    wb_rd_n = lat_rd;
                    wb_we_n = !mem_we && lat_rwe;
                    valid_n = 1'b1;
                end else if (cnt == TIMEOUT) begin
                    state_n = DONE;
                    req_n = 1'b0;
                    wb_rd_n = lat_rd;
                    err_n = 1'b1;
                    valid_n = 1'b1;
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt <= 8'd0;
            mem_req <= 1'b0;
            mem_we <= 1'b0;
            mem_addr <= '0;
            mem_wdata <= '0;
            lat_rd <= '0;
            lat_m2r <= 1'b0;
            lat_rwe <= 1'b0;
            wb_result <= '0;
            wb_rd <= '0;
            wb_reg_write_en <= 1'b0;
            wb_valid <= 1'b0;
            mem_err <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            mem_req <= req_n;
            mem_we <= we_n;
            mem_addr <= addr_n;
            mem_wdata <= wdata_n;
            lat_rd <= rd_n;
            lat_m2r <= m2r_n;
            lat_rwe <= rwe_n;
            wb_result <= res_n;
            wb_rd <= wb_rd_n;
            wb_reg_write_en <= wb_we_n;
            wb_valid <= valid_n;
            mem_err <= err_n;
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized instruction stream checked against a transaction-level model.
module tb_mem_access_unit;
    import core_pkg::*;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [63:0] alu_out = '0, data = '0, mem_addr, mem_wdata, mem_rdata = '0, wb_result;
    logic [4:0] rd = '0, wb_rd;
    logic mem_read = 1'b0, mem_write = 1'b0, mem_to_reg = 1'b0, reg_write_en = 1'b0;
    logic stall, mem_req, mem_we, mem_ack = 1'b0, wb_reg_write_en, wb_valid, mem_err;

    typedef struct packed {
        logic [63:0] res;
        logic [4:0] rd;
        logic we;
        logic err;
        logic chk;
    } ret_t;

    ret_t exp_q[$];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .alu_out(alu_out), .data(data), .rd(rd),
        .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
        .reg_write_en(reg_write_en), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .wb_result(wb_result), .wb_rd(wb_rd), .wb_reg_write_en(wb_reg_write_en),
        .wb_valid(wb_valid), .mem_err(mem_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    function automatic logic any_out();
        return |{stall, mem_req, mem_we, mem_addr, mem_wdata, wb_result, wb_rd,
                 wb_reg_write_en, wb_valid, mem_err};
    endfunction

    // Each retirement seen on the WB port must match the oldest outstanding model entry.
    task automatic sample();
        ret_t e;
        check("err_needs_valid", 64'(mem_err & ~wb_valid), 64'd0);
        if (wb_valid) begin
            check("retire_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("wb_err", 64'(mem_err), 64'(e.err));
                check("wb_we", 64'(wb_reg_write_en), 64'(e.we));
                if (e.chk) begin
                    check("wb_result", wb_result, e.res);
                    check("wb_rd", 64'(wb_rd), 64'(e.rd));
                end
            end
        end
    endtask

    task automatic do_instr(input logic rd_en, input logic wr_en, input logic m2r, input logic rwe,
                            input logic [63:0] alu, input logic [63:0] dat, input logic [4:0] r,
                            input int k, input logic [63:0] rdata);
        logic mem_op = rd_en | wr_en;
        logic legal = mem_op && alu[2:0] == 3'd0 && !(rd_en && wr_en);
        logic tmo = legal && k > TO + 1;
        int exp_req = legal ? (tmo ? TO + 1 : k) : 0;
        int bcnt = 0, stalls = 0, guard = 0;
        logic stable = 1'b1, s;
        ret_t e;
        e.res = alu; e.rd = r; e.we = rwe; e.err = 1'b0; e.chk = 1'b1;
        if (mem_op && (!legal || tmo)) begin
            e.we = 1'b0; e.err = 1'b1; e.chk = 1'b0;
        end else if (mem_op) begin
            e.res = (rd_en && m2r) ? rdata : alu;
            e.we = rd_en && rwe;
        end
        exp_q.push_back(e);
        mem_read = rd_en; mem_write = wr_en; mem_to_reg = m2r; reg_write_en = rwe;
        alu_out = alu; data = dat; rd = r;
        do begin
            #1;
            sample();
            s = stall;
            if (s) stalls++;
            if (mem_req) begin
                bcnt++;
                if ({mem_addr, mem_wdata, mem_we} !== {alu, dat, wr_en}) stable = 1'b0;
            end
            mem_ack = mem_req ? (bcnt == k) : ($urandom_range(0, 3) == 0);
            mem_rdata = (mem_req && bcnt == k) ? rdata : {$urandom, $urandom};
            @(negedge clk);
            guard++;
        end while (s && guard < 600);
        mem_ack = 1'b0;
        check("req_cycles", 64'(bcnt), 64'(exp_req));
        check("stall_cycles", 64'(stalls), 64'(mem_op ? (legal ? exp_req + 1 : 1) : 0));
        if (legal) check("req_stable", 64'(stable), 64'd1);
    endtask

    task automatic reset_mid_access();
        mem_read = 1'b1; mem_write = 1'b0; mem_to_reg = 1'b1; reg_write_en = 1'b1;
        alu_out = 64'h300; rd = 5'd9; mem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("busy_req", 64'(mem_req), 64'd1);
        #1;
        reset = 1'b0;
        #1;
        check("rst_mem_req", 64'(mem_req), 64'd0);
        check("rst_outputs_zero", 64'(any_out()), 64'd0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
        mem_read = 1'b0; mem_to_reg = 1'b0; alu_out = 64'h77; rd = 5'd3; reg_write_en = 1'b1;
        mem_ack = 1'b1;
        mem_rdata = 64'hBAD0BAD0BAD0BAD0;
        exp_q.push_back('{res: 64'h77, rd: 5'd3, we: 1'b1, err: 1'b0, chk: 1'b1});
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        check("stray_ack_req", 64'(mem_req), 64'd0);
        check("stray_ack_err", 64'(mem_err), 64'd0);
    endtask

    initial begin
        int kind, k;
        logic [63:0] a;
        @(negedge clk);
        check("reset_outputs_zero", 64'(any_out()), 64'd0);
        reset = 1'b1;
        do_instr(0, 0, 0, 1, 64'h1234, 64'h0, 5'd5, 0, 64'h0);
        do_instr(1, 0, 1, 1, 64'h100, 64'h0, 5'd7, 3, 64'hDEADBEEF_CAFEF00D);
        do_instr(0, 1, 0, 1, 64'h208, 64'h55, 5'd8, 1, 64'h0);
        do_instr(1, 0, 1, 1, 64'h103, 64'h0, 5'd4, 1, 64'h0);
        do_instr(1, 0, 1, 1, 64'h400, 64'h0, 5'd6, 100, 64'h1);
        do_instr(1, 0, 1, 1, 64'h408, 64'h0, 5'd6, TO + 1, 64'hA5A5_0000_1111_2222);
        do_instr(1, 1, 0, 1, 64'h410, 64'h9, 5'd2, 1, 64'h0);
        do_instr(1, 0, 0, 1, 64'h418, 64'h0, 5'd1, 2, 64'h1234_5678);
        reset_mid_access();
        for (int i = 0; i < 150; i++) begin
            kind = int'($urandom_range(0, 9));
            k = int'($urandom_range(1, TO + 3));
            a = {$urandom, $urandom} & ~64'h7;
            if (kind < 4)
                do_instr(0, 0, 1'($urandom), 1'($urandom), {$urandom, $urandom}, 64'h0, 5'($urandom), 0, 64'h0);
            else if (kind < 7)
                do_instr(1, 0, 1'($urandom), 1'($urandom), a, 64'h0, 5'($urandom), k, {$urandom, $urandom});
            else if (kind < 9)
                do_instr(0, 1, 1'($urandom), 1'($urandom), a, {$urandom, $urandom}, 5'($urandom), k, 64'h0);
            else
                do_instr(1'($urandom), 1'b1, 1'b1, 1'b1, a | 64'($urandom_range(0, 7)), 64'h0, 5'($urandom), k, 64'h0);
        end
        mem_read = 1'b0; mem_write = 1'b0;
        #1;
        sample();
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
